// File: rtl/dw_window_generator_if.sv
// Pixel-in / window-out stream bundle for dw_window_generator.
//   pixel_in, pixel_valid, pixel_ready     : raster-order uint8 activation stream
//   window_out[k], k = 3*dy + dx           : 3x3 window, dy=0 top row, dx=0 left column
//   window_valid, window_ready             : window handshake
//   window_row, window_col                 : output-map coordinates of window_out
// The slave modport is the generator's view; the master modport is the producer/consumer side.
interface dw_window_generator_if;
  logic [7:0]      pixel_in;
  logic            pixel_valid;
  logic            pixel_ready;
  logic [8:0][7:0] window_out;
  logic            window_valid;
  logic            window_ready;
  logic [7:0]      window_row;
  logic [7:0]      window_col;

  modport master (
    output pixel_in, pixel_valid, window_ready,
    input  pixel_ready, window_out, window_valid, window_row, window_col
  );

  modport slave (
    input  pixel_in, pixel_valid, window_ready,
    output pixel_ready, window_out, window_valid, window_row, window_col
  );
endinterface

// File: rtl/dw_window_generator.sv
// Line-buffer 3x3 sliding-window generator ("valid" windowing, stride 1 or 2).
// Ports:
//   clock, reset        : clock; synchronous active-high reset
//   cfg_width/height    : frame size W (3..MAX_WIDTH) and H (3..255), latched on frame_start
//   cfg_stride2         : 0 = stride 1, 1 = stride 2
//   frame_start         : start pulse, only honoured while idle
//   strm                : pixel input and window output streams (slave side)
//   frame_done          : one-cycle pulse after the last window is consumed
//   cfg_error           : one-cycle pulse after a frame_start with an illegal configuration
//   busy                : high whenever a frame is in progress
module dw_window_generator #(
  parameter int unsigned MAX_WIDTH = 112
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           cfg_width,
  input  logic [7:0]           cfg_height,
  input  logic                 cfg_stride2,
  input  logic                 frame_start,
  dw_window_generator_if.slave strm,
  output logic                 frame_done,
  output logic                 cfg_error,
  output logic                 busy
);

  localparam int unsigned LbAw      = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [8:0]  MaxWidth9 = 9'(MAX_WIDTH);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

  state_e          state_q;
  logic [7:0]      width_q, height_q;
  logic            stride2_q;
  logic [7:0]      ir_q, ic_q;
  logic [8:0][7:0] win_q, win_d;
  logic            win_valid_q;
  logic [7:0]      row_q, col_q;
  logic            frame_done_q, cfg_error_q;

  // Two previous rows; not reset, emission waits until both have been written this frame.
  logic [7:0] lb_top [MAX_WIDTH];
  logic [7:0] lb_mid [MAX_WIDTH];

  logic            cfg_ok;
  logic            pix_ready;
  logic            accept;
  logic            emit;
  logic            last_col, last_row;
  logic [LbAw-1:0] lb_idx;
  logic [7:0]      col_top, col_mid;
  logic [7:0]      row_base, col_base;

  assign cfg_ok = (cfg_width >= 8'd3) && ({1'b0, cfg_width} <= MaxWidth9) &&
                  (cfg_height >= 8'd3);

  // Combinational from window_ready so a consumed window frees the slot in the same cycle.
  assign pix_ready = (state_q == StStream) && (!win_valid_q || strm.window_ready);
  assign accept    = strm.pixel_valid && pix_ready;

  assign lb_idx   = ic_q[LbAw-1:0];
  assign col_top  = lb_top[lb_idx];
  assign col_mid  = lb_mid[lb_idx];
  assign last_col = (ic_q == width_q - 8'd1);
  assign last_row = (ir_q == height_q - 8'd1);
  assign emit     = (ir_q >= 8'd2) && (ic_q >= 8'd2) && (!stride2_q || (!ir_q[0] && !ic_q[0]));
  assign row_base = ir_q - 8'd2;
  assign col_base = ic_q - 8'd2;

  // Shift the window left one column; the new column enters at dx=2.
  always_comb begin
    win_d    = win_q;
    win_d[0] = win_q[1];
    win_d[1] = win_q[2];
    win_d[2] = col_top;
    win_d[3] = win_q[4];
    win_d[4] = win_q[5];
    win_d[5] = col_mid;
    win_d[6] = win_q[7];
    win_d[7] = win_q[8];
    win_d[8] = strm.pixel_in;
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      lb_top[lb_idx] <= col_mid;
      lb_mid[lb_idx] <= strm.pixel_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      width_q      <= '0;
      height_q     <= '0;
      stride2_q    <= 1'b0;
      ir_q         <= '0;
      ic_q         <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      cfg_error_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      cfg_error_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (frame_start) begin
            if (cfg_ok) begin
              width_q   <= cfg_width;
              height_q  <= cfg_height;
              stride2_q <= cfg_stride2;
              ir_q      <= '0;
              ic_q      <= '0;
              state_q   <= StStream;
            end else begin
              cfg_error_q <= 1'b1;
            end
          end
        end
        StStream: begin
          if (accept) begin
            win_q <= win_d;
            if (last_col) begin
              ic_q <= '0;
              ir_q <= ir_q + 8'd1;
            end else begin
              ic_q <= ic_q + 8'd1;
            end
            if (emit) begin
              win_valid_q <= 1'b1;
              row_q       <= stride2_q ? {1'b0, row_base[7:1]} : row_base;
              col_q       <= stride2_q ? {1'b0, col_base[7:1]} : col_base;
            end else if (strm.window_ready) begin
              win_valid_q <= 1'b0;
            end
            if (last_col && last_row) begin
              state_q <= StDrain;
            end
          end else if (strm.window_ready) begin
            win_valid_q <= 1'b0;
          end
        end
        StDrain: begin
          if (!win_valid_q || strm.window_ready) begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign strm.pixel_ready  = pix_ready;
  assign strm.window_out   = win_q;
  assign strm.window_valid = win_valid_q;
  assign strm.window_row   = row_q;
  assign strm.window_col   = col_q;
  assign frame_done        = frame_done_q;
  assign cfg_error         = cfg_error_q;
  assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_dw_window_generator.sv
// Bench for dw_window_generator: directed frames plus randomized gaps, backpressure and
// frame shapes, compared against a window list computed directly from the frame image.
module tb_dw_window_generator;
  localparam int MaxW = 112;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] cfg_width, cfg_height;
  logic       cfg_stride2, frame_start;
  logic       frame_done, cfg_error, busy;

  dw_window_generator_if strm ();

  dw_window_generator #(.MAX_WIDTH(MaxW)) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .cfg_stride2 (cfg_stride2),
    .frame_start (frame_start),
    .strm        (strm.slave),
    .frame_done  (frame_done),
    .cfg_error   (cfg_error),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0]  fr [0:15][0:127];
  logic [87:0] exp_q [$];
  int          acc_cyc [0:2047];
  int          nwin = 0, ndone = 0, first_win_cyc = 0;
  bit          first_seen = 0, prev_stall = 0;
  logic [87:0] first_win, last_win, prev_win, cur;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic chk_w(input string name, input logic [87:0] got, input logic [87:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [71:0] pk9(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7,
                                      input int a8);
    logic [71:0] v;
    v = {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    return v;
  endfunction

  // Every consumed window must be the next one in raster output order.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      cur = {strm.window_row, strm.window_col, strm.window_out};
      if (prev_stall) begin
        chk("hold_valid", int'(strm.window_valid), 1);
        chk_w("hold_data", cur, prev_win);
      end
      if (strm.window_valid && !strm.window_ready)
        chk("stall_pixel_ready", int'(strm.pixel_ready), 0);
      if (strm.window_valid && !first_seen) begin
        first_seen    = 1;
        first_win_cyc = cyc;
        first_win     = cur;
      end
      if (strm.window_valid && strm.window_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_window: got %h expected no window", cur);
        end else begin
          chk_w("window", cur, exp_q.pop_front());
        end
        last_win = cur;
        nwin++;
      end
      prev_stall = strm.window_valid && !strm.window_ready;
      prev_win   = cur;
      if (frame_done) ndone++;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pixel_ready"}, int'(strm.pixel_ready), 0);
    chk({tag, "_window_valid"}, int'(strm.window_valid), 0);
    chk_w({tag, "_window"}, {strm.window_row, strm.window_col, strm.window_out}, '0);
    chk({tag, "_flags"}, int'({frame_done, cfg_error, busy}), 0);
  endtask

  task automatic run_frame(input int w, input int h, input bit s2, input int gap_pct,
                           input int ready_pct, input int stall_len, input int abort_after,
                           input bit rnd_pix);
    int  idx, budget, stall_left, d0, s;
    bit  acc, done, stalled;
    logic [71:0] wv;
    s = s2 ? 2 : 1;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        fr[r][c] = rnd_pix ? 8'($urandom_range(255)) : 8'(r * w + c + 1);
    exp_q.delete();
    for (int orow = 0; s * orow + 2 < h; orow++)
      for (int ocol = 0; s * ocol + 2 < w; ocol++) begin
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++)
            wv[8 * (3 * dy + dx) +: 8] = fr[s * orow + dy][s * ocol + dx];
        exp_q.push_back({8'(orow), 8'(ocol), wv});
      end

    @(posedge clock); #1;
    nwin = 0;
    first_seen = 0;
    d0 = ndone;
    cfg_width = 8'(w);
    cfg_height = 8'(h);
    cfg_stride2 = s2;
    frame_start = 1;
    strm.window_ready = 1;
    strm.pixel_valid = 0;
    @(posedge clock); #1;
    frame_start = 0;
    @(negedge clock);
    chk("start_busy", int'(busy), 1);
    chk("start_pixel_ready", int'(strm.pixel_ready), 1);

    idx = 0; acc = 0; done = 0; stalled = 0; stall_left = 0;
    budget = 8 * w * h + 100;
    for (int t = 0; t < budget && !done; t++) begin
      @(posedge clock); #1;
      if (acc) idx++;
      if (abort_after > 0 && idx == abort_after) return;
      strm.pixel_valid = (idx < w * h) && ($urandom_range(99) >= gap_pct);
      strm.pixel_in = (idx < w * h) ? fr[idx / w][idx % w] : 8'h00;
      if (stall_left > 0) begin
        strm.window_ready = 0;
        stall_left--;
      end else begin
        strm.window_ready = ($urandom_range(99) < ready_pct);
      end
      @(negedge clock);
      acc = strm.pixel_valid && strm.pixel_ready;
      if (acc) acc_cyc[idx] = cyc;
      if (frame_done) done = 1;
      if (stall_len > 0 && !stalled && strm.window_valid) begin
        stalled = 1;
        stall_left = stall_len;
      end
    end
    strm.pixel_valid = 0;
    strm.window_ready = 1;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: got no frame_done expected one (w=%0d h=%0d)", w, h);
    end else begin
      @(negedge clock); #1;
      chk("idle_after_done", int'(busy), 0);
      chk("frame_done_pulses", ndone - d0, 1);
      chk("window_count", nwin, s2 ? ((h - 1) / 2) * ((w - 1) / 2) : (h - 2) * (w - 2));
      chk("model_drained", exp_q.size(), 0);
      chk("first_window_latency", first_win_cyc - acc_cyc[2 * w + 2], 1);
    end
  endtask

  task automatic try_illegal(input int w, input int h);
    @(posedge clock); #1;
    cfg_width = 8'(w);
    cfg_height = 8'(h);
    cfg_stride2 = 0;
    frame_start = 1;
    @(posedge clock); #1;
    frame_start = 0;
    @(negedge clock);
    chk("cfg_error_pulse", int'(cfg_error), 1);
    chk("cfg_error_busy", int'(busy), 0);
    chk("cfg_error_pixel_ready", int'(strm.pixel_ready), 0);
    @(negedge clock);
    chk("cfg_error_once", int'(cfg_error), 0);
  endtask

  logic [87:0] s1_first, s1_last;
  int d0;

  initial begin
    reset = 1;
    frame_start = 0;
    cfg_width = 0;
    cfg_height = 0;
    cfg_stride2 = 0;
    strm.pixel_valid = 0;
    strm.pixel_in = 0;
    strm.window_ready = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("reset");
    @(posedge clock); #1;
    reset = 0;

    s1_first = {8'd0, 8'd0, pk9(1, 2, 3, 5, 6, 7, 9, 10, 11)};
    s1_last  = {8'd1, 8'd1, pk9(6, 7, 8, 10, 11, 12, 14, 15, 16)};

    run_frame(4, 4, 0, 0, 100, 0, 0, 0);
    chk_w("s1_first_literal", first_win, s1_first);
    chk_w("s1_last_literal", last_win, s1_last);

    run_frame(5, 5, 1, 0, 100, 0, 0, 0);
    chk_w("s2_first_literal", first_win, {8'd0, 8'd0, pk9(1, 2, 3, 6, 7, 8, 11, 12, 13)});
    chk_w("s2_last_literal", last_win, {8'd1, 8'd1, pk9(13, 14, 15, 18, 19, 20, 23, 24, 25)});

    run_frame(4, 4, 0, 0, 100, 5, 0, 0);
    chk_w("stall_first_literal", first_win, s1_first);
    chk_w("stall_last_literal", last_win, s1_last);

    try_illegal(2, 4);
    try_illegal(MaxW + 1, 4);
    try_illegal(5, 2);
    run_frame(3, 3, 0, 0, 100, 0, 0, 0);
    chk_w("w3h3_literal", first_win, {8'd0, 8'd0, pk9(1, 2, 3, 4, 5, 6, 7, 8, 9)});

    run_frame(4, 4, 0, 0, 100, 0, 7, 0);
    d0 = ndone;
    strm.pixel_valid = 0;
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("midframe_reset");
    @(posedge clock); #1;
    reset = 0;
    exp_q.delete();
    repeat (3) @(posedge clock);
    chk("midframe_no_done", ndone - d0, 0);
    run_frame(4, 4, 0, 0, 100, 0, 0, 0);
    chk_w("recover_first_literal", first_win, s1_first);
    chk_w("recover_last_literal", last_win, s1_last);

    run_frame(6, 6, 0, 30, 100, 0, 0, 1);

    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(12, 3), $urandom_range(12, 3), 1'($urandom_range(1)),
                $urandom_range(40), $urandom_range(100, 50), 0, 0, 1);

    run_frame(MaxW, 3, 0, 10, 80, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
